pb_cond: RTL and testbench

PB_COND -- requirements
Module: pb_cond

---
 rtl/pb_cond.sv | 135 +++++++++++++
 tb/tb_pb_cond.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pb_cond.sv
// pb_cond: push-button conditioner, N independent channels.
// Each channel synchronizes its raw button input, debounces it on ena
// ticks, and produces press/release edge pulses plus auto-repeat pulses
// while the button stays held.
//
// Ports:
//   clk    in  1  system clock, all state on rising edge
//   rst    in  1  asynchronous active-high reset
//   ena    in  1  sampling tick; debounce and hold counters advance only here
//   pb     in  N  raw asynchronous button inputs
//   level  out N  debounced active-high button state
//   press  out N  one-clk pulse in the first cycle level is 1
//   rel    out N  one-clk pulse in the first cycle level is 0 (release;
//                 "release" itself is a reserved word)
//   rep    out N  one-clk auto-repeat pulse while held
//
// Per-channel FSM:
//   state  | meaning
//   IDLE   | button not held (level = 0)
//   HOLD   | held, counting ena ticks towards the first repeat
//   REPEAT | held, emitting a repeat pulse every REP_CYC ena ticks
module pb_cond #(
  parameter int N        = 2,
  parameter int DB_CYC   = 4,
  parameter int HOLD_CYC = 8,
  parameter int REP_CYC  = 3,
  parameter bit INV      = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [N-1:0] pb,
  output logic [N-1:0] level,
  output logic [N-1:0] press,
  output logic [N-1:0] rel,
  output logic [N-1:0] rep
);

  localparam int DW   = $clog2(DB_CYC + 1);
  localparam int HMAX = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYC - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REP_CYC - 1);
  // Synchronizer reset value chosen so the conditioned input reads inactive.
  localparam logic [N-1:0]  SYNC_RST  = {N{INV}};

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} st_t;

  logic [N-1:0] sync1, sync2, s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= SYNC_RST;
      sync2 <= SYNC_RST;
    end else begin
      sync1 <= pb;
      sync2 <= sync1;
    end
  end

  assign s = INV ? ~sync2 : sync2;

  for (genvar i = 0; i < N; i++) begin : g_ch
    st_t           st;
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hcnt;
    logic          lvl, prs, rls, rp;
    logic          mis, tog;

    assign mis = ena && (s[i] != lvl);
    // Last mismatching tick of the debounce window: level flips this edge.
    assign tog = mis && (dcnt == DB_LAST);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st   <= IDLE;
        dcnt <= '0;
        hcnt <= '0;
        lvl  <= 1'b0;
        prs  <= 1'b0;
        rls  <= 1'b0;
        rp   <= 1'b0;
      end else begin
        prs <= tog && s[i];
        rls <= tog && !s[i];
        rp  <= 1'b0;

        if (tog) begin
          lvl  <= s[i];
          dcnt <= '0;
        end else if (mis) begin
          dcnt <= dcnt + 1'b1;
        end else if (ena) begin
          dcnt <= '0;
        end

        // A level change overrides the hold/repeat sequencing, so a
        // release can never coincide with a repeat pulse.
        if (tog) begin
          st   <= s[i] ? HOLD : IDLE;
          hcnt <= '0;
        end else if (ena) begin
          case (st)
            HOLD: begin
              if (hcnt == HOLD_LAST) begin
                st   <= REPEAT;
                hcnt <= '0;
                rp   <= 1'b1;
              end else begin
                hcnt <= hcnt + 1'b1;
              end
            end
            REPEAT: begin
              if (hcnt == REP_LAST) begin
                hcnt <= '0;
                rp   <= 1'b1;
              end else begin
                hcnt <= hcnt + 1'b1;
              end
            end
            default: hcnt <= '0;
          endcase
        end
      end
    end

    assign level[i] = lvl;
    assign press[i] = prs;
    assign rel[i]   = rls;
    assign rep[i]   = rp;
  end

endmodule

// File: tb/tb_pb_cond.sv
// Testbench for pb_cond: two instances (active-high and active-low buttons)
// driven with directed and random stimulus; a reference model pushes the
// expected outputs of every cycle into per-instance queues and a monitor
// pops and compares them against the DUT outputs.
module tb_pb_cond;

  localparam int DB   = 4;
  localparam int HOLD = 8;
  localparam int REP  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [1:0] pb0, pb1;
  logic [1:0] lv0, pr0, rl0, rp0;
  logic [1:0] lv1, pr1, rl1, rp1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pb_cond #(.N(2), .DB_CYC(DB), .HOLD_CYC(HOLD), .REP_CYC(REP), .INV(1'b0)) dut0 (
    .clk(clk), .rst(rst), .ena(ena), .pb(pb0),
    .level(lv0), .press(pr0), .rel(rl0), .rep(rp0)
  );

  pb_cond #(.N(2), .DB_CYC(DB), .HOLD_CYC(HOLD), .REP_CYC(REP), .INV(1'b1)) dut1 (
    .clk(clk), .rst(rst), .ena(ena), .pb(pb1),
    .level(lv1), .press(pr1), .rel(rl1), .rep(rp1)
  );

  typedef struct packed {
    logic [1:0] lvl;
    logic [1:0] prs;
    logic [1:0] rls;
    logic [1:0] rp;
  } out_t;

  out_t expq0[$];
  out_t expq1[$];

  // Reference model state: raw-input history (two-cycle synchronizer delay),
  // consecutive mismatch count, and ena ticks elapsed since the last press
  // (-1 when the button is not held).
  logic [1:0] hist_old[2];
  logic [1:0] hist_new[2];
  logic [1:0] mlvl[2];
  int         mism[2][2];
  int         ticks[2][2];

  function automatic void model_reset(int k, logic inv);
    hist_old[k] = inv ? 2'b11 : 2'b00;
    hist_new[k] = inv ? 2'b11 : 2'b00;
    mlvl[k]     = 2'b00;
    for (int c = 0; c < 2; c++) begin
      mism[k][c]  = 0;
      ticks[k][c] = -1;
    end
  endfunction

  function automatic out_t model_step(int k, logic [1:0] pbv, logic inv, logic en);
    out_t       o;
    logic [1:0] sv;
    logic       toggled;
    o  = '0;
    sv = inv ? ~hist_old[k] : hist_old[k];
    hist_old[k] = hist_new[k];
    hist_new[k] = pbv;
    for (int c = 0; c < 2; c++) begin
      toggled = 1'b0;
      if (en) begin
        if (sv[c] != mlvl[k][c]) begin
          mism[k][c]++;
          if (mism[k][c] == DB) begin
            mlvl[k][c] = sv[c];
            mism[k][c] = 0;
            toggled    = 1'b1;
            if (sv[c]) begin
              o.prs[c]    = 1'b1;
              ticks[k][c] = 0;
            end else begin
              o.rls[c]    = 1'b1;
              ticks[k][c] = -1;
            end
          end
        end else begin
          mism[k][c] = 0;
        end
        if (!toggled && ticks[k][c] >= 0) begin
          ticks[k][c]++;
          if (ticks[k][c] == HOLD ||
              (ticks[k][c] > HOLD && (ticks[k][c] - HOLD) % REP == 0))
            o.rp[c] = 1'b1;
        end
      end
    end
    o.lvl = mlvl[k];
    return o;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      model_reset(0, 1'b0);
      model_reset(1, 1'b1);
      expq0.push_back('0);
      expq1.push_back('0);
    end else begin
      expq0.push_back(model_step(0, pb0, 1'b0, ena));
      expq1.push_back(model_step(1, pb1, 1'b1, ena));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents a full output vector per instance.
  initial begin
    out_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq0.size() == 0) chk("dut0_queue_empty", 32'd0, 32'd1);
      else begin
        e = expq0.pop_front();
        chk("dut0_outputs", {24'd0, lv0, pr0, rl0, rp0}, {24'd0, e});
      end
      if (expq1.size() == 0) chk("dut1_queue_empty", 32'd0, 32'd1);
      else begin
        e = expq1.pop_front();
        chk("dut1_outputs", {24'd0, lv1, pr1, rl1, rp1}, {24'd0, e});
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bounded wait for press[0] of the active-high instance; cycles counted
  // from the current negedge.
  task automatic measure_press0(output int lat);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (pr0[0] && lat < 0) lat = c;
    end
  endtask

  int lat;

  initial begin
    rst = 1'b1;
    ena = 1'b1;
    pb0 = 2'b00;
    pb1 = 2'b11;
    cycles(3);
    chk("reset_outputs_dut0", {24'd0, lv0, pr0, rl0, rp0}, 32'd0);
    chk("reset_outputs_dut1", {24'd0, lv1, pr1, rl1, rp1}, 32'd0);
    rst = 1'b0;

    // Single press, latency, long hold with repeats, then release.
    cycles(5);
    pb0 = 2'b01;
    measure_press0(lat);
    chk("press_latency", lat, 6);
    cycles(30);
    pb0 = 2'b00;
    cycles(10);

    // Bouncing input shorter than the debounce window.
    for (int i = 0; i < 10; i++) begin
      pb0[0] = ~pb0[0];
      cycles(2);
    end
    pb0 = 2'b00;
    cycles(8);

    // Active-low instance: press on channel 0 and release.
    pb1[0] = 1'b0;
    cycles(15);
    pb1 = 2'b11;
    cycles(10);

    // Sparse ena: one tick every 4 cycles.
    for (int cyc = 0; cyc < 160; cyc++) begin
      ena = (cyc % 4 == 0);
      if (cyc == 10) pb0[1] = 1'b1;
      if (cyc == 90) pb0[1] = 1'b0;
      cycles(1);
    end
    ena = 1'b1;
    cycles(10);

    // Random phase: slowly changing buttons, random ena.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      ena = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(0, 11) == 0) pb0[c] = ~pb0[c];
        if ($urandom_range(0, 11) == 0) pb1[c] = ~pb1[c];
      end
      cycles(1);
    end

    // Reset while channel 0 is in the repeat phase with the button held.
    ena = 1'b1;
    pb0 = 2'b00;
    pb1 = 2'b11;
    cycles(12);
    pb0 = 2'b01;
    cycles(20);
    rst = 1'b1;
    #1;
    chk("midrepeat_reset_dut0", {24'd0, lv0, pr0, rl0, rp0}, 32'd0);
    cycles(2);
    rst = 1'b0;
    measure_press0(lat);
    chk("press_after_reset", lat, 6);
    cycles(5);
    pb0 = 2'b00;
    cycles(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
